mem_lsu: RTL
============

# mem_lsu

Load/store initiator that drives the byte-masked, single-cycle memory port (word address, read strobe, 4-bit write mask, registered read data) on behalf of the core. It accepts one RV32 load/store request at a time and checks alignment and range. It generates lane masks and replicated write data, waits a parameterised read latency, then returns sign- or zero-extended load data or a store completion. It sits between the execute stage and the data memory.

## Interface
- ADDR_WIDTH, 22: memory byte-address width (4 MiB); must be 3..31.
- MEM_LATENCY, 1: cycles from the read-strobe cycle to valid mem_rdata_i; must be ≥1.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high only in IDLE; a transfer occurs when valid&ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  qualified by rsp_valid_o: misaligned, illegal funct3 or out-of-range.
- mem_addr_o  out  ADDR_WIDTH  byte address to memory.
- mem_rstrb_o  out  1  read strobe.
- mem_rdata_i  in  32  memory read data.
- mem_wmask_o  out  4  byte-lane write enables.
- mem_wdata_o  out  32  lane-replicated write data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready_o=1. On accept, the request is checked:
  - error if funct3 ∉ {000,001,010,100,101}, or store with funct3 ∈ {100,101};
  - error if H/HU with addr[0]=1, or W with addr[1:0]≠0;
  - error if req_addr_i[31:ADDR_WIDTH]≠0.
  - Error → RESP with rsp_err_o=1, rsp_rdata_o=0, no memory activity.
  - Otherwise latch addr, width, we and data, and go to ISSUE.
- ISSUE (exactly one cycle): mem_addr_o = latched addr[ADDR_WIDTH-1:0].
  - Store: mem_wmask_o is B: 1<<addr[1:0]; H: addr[1]?1100:0011; W: 1111.
  - Store mem_wdata_o is B: {4{d[7:0]}}; H: {2{d[15:0]}}; W: d. Then → RESP.
  - Load: mem_rstrb_o=1, wmask=0, then → WAIT with latency counter loaded to MEM_LATENCY-1.
- WAIT: counter decrements each cycle. When it reaches 0:
  - sample mem_rdata_i and select lane (B/BU by addr[1:0], H/HU by addr[1]);
  - sign-extend for B/H, zero-extend for BU/HU, pass W through;
  - register into rsp_rdata_o and go to RESP.
- RESP: rsp_valid_o=1 for one cycle, then → IDLE. rsp_rdata_o/rsp_err_o hold until the next RESP.
- Outside ISSUE: mem_rstrb_o=0 and mem_wmask_o=0. mem_addr_o and mem_wdata_o hold their last values.
- All mem_* and rsp_* outputs are registered; none is combinational from req_*.

## Timing
- Accept in cycle 0.
- Store: ISSUE cycle 1, where memory commits on the edge ending cycle 1. rsp_valid_o in cycle 2.
- Load: ISSUE cycle 1, WAIT cycles 2..1+MEM_LATENCY. rsp_valid_o in cycle 2+MEM_LATENCY, which is cycle 3 by default.
- Error: rsp_valid_o in cycle 1.
- Throughput: one request per (response cycle + 1). A new request is accepted in the cycle after RESP.
- req_valid_i held while not ready: no effect, no sampling.
- Reset (rst_ni=0, any time): immediately set state=IDLE and all outputs 0 except req_ready_o. req_ready_o=1 once state is IDLE.
- Reset mid-operation abandons the request: no response, and no strobe or mask is seen after reset.

## Test plan
- SW addr 0x100 data 0xDEADBEEF → cycle 1: mem_addr_o=0x100, wmask=1111, wdata=0xDEADBEEF; cycle 2: rsp_valid_o, err=0. Then LW 0x100 with memory returning 0xDEADBEEF → rstrb in cycle 1 only, rsp_rdata_o=0xDEADBEEF in cycle 3.
- SB addr 0x103 data 0x0000_0080 → wmask=1000, wdata=0x80808080. Then LB 0x103 with rdata 0x80xxxxxx → 0xFFFFFF80; LBU → 0x00000080.
- SH 0x102 data 0x8001 → wmask=1100, wdata=0x80018001. Then LH 0x102 with rdata 0x8001xxxx → 0xFFFF8001; LHU → 0x00008001.
- Errors → rsp_valid_o in cycle 1 with err=1, rdata=0, and rstrb/wmask never asserted, for each of:
  - LH 0x101;
  - LW 0x102;
  - SB with funct3=100;
  - LW 0x0040_0000 (ADDR_WIDTH=22).
- MEM_LATENCY=3: LW 0x8 with rdata valid only in cycle 4 → rsp_rdata_o equals that value, rsp_valid_o in cycle 5. req_valid_i held continuously → req_ready_o low in cycles 1–5, next accept in cycle 6.
- Assert rst_ni low during WAIT of an LW → rsp_valid_o never pulses and outputs go 0 asynchronously. After release, req_ready_o=1 and a following SW completes normally.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Core-side request/response and memory-side port bundle of the load/store unit.
// The slave modport is the LSU view; master is the core + memory environment view.
interface mem_lsu_if #(
  parameter int ADDR_WIDTH = 22
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [31:0]           req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rstrb_o;
  logic [31:0]           mem_rdata_i;
  logic [3:0]            mem_wmask_o;
  logic [31:0]           mem_wdata_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_addr_o, mem_rstrb_o, mem_wmask_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_addr_o, mem_rstrb_o, mem_wmask_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_lsu.sv
// RV32 load/store initiator: checks a single request, drives the byte-masked memory
// port for one cycle, waits MEM_LATENCY for read data and returns extended load data.
module mem_lsu #(
  parameter int ADDR_WIDTH  = 22,
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  mem_lsu_if.slave   bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rstrb_q, mem_rstrb_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  we_q, we_d;
  logic [1:0]            off_q, off_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = (addr[1:0] != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | ((addr >> ADDR_WIDTH) != 32'd0);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_rstrb_d = mem_rstrb_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    we_d        = we_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (req_bad(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i)) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            // Memory outputs are loaded here so they are registered during ISSUE.
            state_d    = ISSUE;
            mem_addr_d = bus.req_addr_i[ADDR_WIDTH-1:0];
            f3_d       = bus.req_funct3_i;
            we_d       = bus.req_we_i;
            off_d      = bus.req_addr_i[1:0];
            if (bus.req_we_i) begin
              mem_wmask_d = lane_mask(bus.req_funct3_i[1:0], bus.req_addr_i[1:0]);
              mem_wdata_d = lane_data(bus.req_funct3_i[1:0], bus.req_wdata_i);
            end else begin
              mem_rstrb_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        mem_rstrb_d = 1'b0;
        mem_wmask_d = 4'b0000;
        if (we_q) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_extend(f3_q, off_q, bus.mem_rdata_i);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_rstrb_q <= 1'b0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_rstrb_q <= mem_rstrb_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_rstrb_o = mem_rstrb_q;
  assign bus.mem_wmask_o = mem_wmask_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule
